// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer with a registered 2*WIDTH-bit answer and status.
// Define CALC_SEQ_DIV_EN to build the restoring divider; otherwise opcode 011 is invalid.
module calc_op_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic [2:0]           opcode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 error
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
`ifdef CALC_SEQ_DIV_EN
  localparam logic [2:0] OpDiv = 3'b011;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               error_q, error_d;

  logic               iter_start;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] iter_step;

  // prod_q = {upper accumulator, multiplier}; shift right one bit per cycle.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef CALC_SEQ_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;

  // prod_q = {partial remainder, dividend/quotient}; quotient bits enter at the LSB.
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_step  = {div_rem, prod_q[WIDTH-2:0], div_ge};
  assign iter_step = (op_q == OpDiv) ? div_step : mul_step;
  assign iter_start = (opcode == OpMul) || ((opcode == OpDiv) && (num2 != '0));
`else
  assign iter_step  = mul_step;
  assign iter_start = (opcode == OpMul);
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (start && !clear) begin
          a_d     = num1;
          b_d     = num2;
          op_d    = opcode;
          error_d = 1'b0;
          cnt_d   = CntInit;
          prod_d  = {{WIDTH{1'b0}}, num1};
          state_d = iter_start ? StIter : StExec;
        end
      end
      StExec: begin
        if (clear) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          case (op_q)
            OpAdd: result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            OpSub: result_d = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
`ifdef CALC_SEQ_DIV_EN
            // Only a zero divisor reaches EXEC with a divide opcode.
            OpDiv: begin
              result_d = {a_q, {WIDTH{1'b1}}};
              error_d  = 1'b1;
            end
`endif
            default: begin
              result_d = '0;
              error_d  = 1'b1;
            end
          endcase
        end
      end
      StIter: begin
        if (clear) begin
          state_d = StIdle;
        end else begin
          prod_d = iter_step;
          cnt_d  = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            result_d = iter_step;
            state_d  = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: random and directed operations against an
// arithmetic reference model; honours CALC_SEQ_DIV_EN the same way as the design.
module tb_calc_op_sequencer;

  localparam int unsigned W = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          clear;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic [2:0]    opcode;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          error;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .clear  (clear),
    .num1   (num1),
    .num2   (num2),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operands; lat counts cycles from the start edge to done.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] op, output logic [31:0] res,
                                output logic err, output int lat);
    err = 1'b0;
    lat = 2;
    case (op)
      3'd0: res = 32'(a) + 32'(b);
      3'd1: res = 32'(a) - 32'(b);
      3'd2: begin res = 32'(a) * 32'(b); lat = 1 + W; end
`ifdef CALC_SEQ_DIV_EN
      3'd3: begin
        if (b == 0) begin
          res = {a, 16'hFFFF};
          err = 1'b1;
        end else begin
          res = {a % b, a / b};
          lat = 1 + W;
        end
      end
`endif
      default: begin res = '0; err = 1'b1; end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_result", result, e.res);
          check("done_error", error, e.err);
          check("done_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=none required=cycle_%0d (t=%0t)", sb[0].cyc, $time);
        void'(sb.pop_front());
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input bit noise);
    exp_t e;
    int   lat;
    int   n;
    @(negedge clk);
    num1 = a; num2 = b; opcode = op; start = 1'b1;
    model(a, b, op, e.res, e.err, lat);
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    check("result_held", result, last_res);
    last_res = e.res;
    n = 0;
    while (busy && n < 40) begin
      if (noise) begin
        num1 = 16'($urandom); num2 = 16'($urandom); opcode = 3'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("busy_drops", busy, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   op;
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    num1 = '0; num2 = '0; opcode = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_error", error, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op(16'hFFFF, 16'h0001, 3'd0, 1'b0);
    do_op(16'h0005, 16'h0009, 3'd1, 1'b0);
    do_op(16'h0009, 16'h0005, 3'd1, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 3'd2, 1'b0);
    do_op(16'h0000, 16'h1234, 3'd2, 1'b0);
    do_op(16'h0064, 16'h0007, 3'd3, 1'b0);
    do_op(16'h1234, 16'h0000, 3'd3, 1'b0);
    do_op(16'h1234, 16'h5678, 3'd7, 1'b0);
    do_op(16'hABCD, 16'h0013, 3'd3, 1'b0);

    // Mul aborted by clear; a start in flight must be ignored.
    @(negedge clk);
    num1 = 16'hFFFF; num2 = 16'h0003; opcode = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    num1 = 16'h0001; num2 = 16'h0001; opcode = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_clear", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_result_held", result, last_res);
    check("clear_error", error, 0);
    repeat (25) @(negedge clk);

    // clear together with start in IDLE: nothing starts.
    num1 = 16'h0003; num2 = 16'h0004; opcode = 3'd0; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("clear_wins_busy", busy, 0);
    repeat (3) @(negedge clk);

    // clear in the DONE cycle does not suppress done.
    begin
      exp_t e;
      int   lat;
      num1 = 16'h0007; num2 = 16'h0008; opcode = 3'd0; start = 1'b1;
      model(16'h0007, 16'h0008, 3'd0, e.res, e.err, lat);
      e.cyc = cyc + lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("done_clear_idle", busy, 0);
      last_res = e.res;
    end

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      do_op(a, b, op, 1'b1);
    end

    do_op(16'h00FF, 16'h0100, 3'd2, 1'b0);

    // Async reset between edges in the middle of an iterative op.
    @(negedge clk);
    num1 = 16'h1111; num2 = 16'h2222; opcode = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_result", result, 0);
    check("async_reset_error", error, 0);
    check("async_reset_done", done, 0);
    last_res = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(16'h0002, 16'h0003, 3'd0, 1'b0);

    repeat (30) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Multi-cycle arithmetic sequencer for the Basys3 calculator. It sits between the stage selector/data collector and the seven-segment display. On a start pulse it latches the stored operands and opcode, then runs one of these:
- single-cycle add/sub
- iterative shift-add multiply
- iterative restoring divide

It then presents a registered 32-bit answer with busy/done/error status. It replaces the combinational 16x16 multiplier in the answer path so that one shared adder/shifter serves every operation.

Parameters:
WIDTH, 16, operand width; result is 2*WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  system clock (100 MHz board clock).
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request pulse, already debounced/edge-detected by caller; sampled only in IDLE.
clear  input  1  synchronous abort; returns to IDLE without done.
num1  input  WIDTH  operand A (unsigned).
num2  input  WIDTH  operand B (unsigned).
opcode  input  3  000 add, 001 sub, 010 mul, 011 div, others invalid.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse in the DONE state.
result  output  2*WIDTH  registered answer; held until the next completed operation.
error  output  1  set with result on invalid opcode or divide-by-zero; cleared on next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, error=0, internal operand/accumulator/counter regs=0.
- States: IDLE, EXEC, ITER, DONE.
- IDLE: start=1 and clear=0 -> latch num1, num2, opcode; clear error; go to EXEC for add/sub/invalid/div-by-zero, else ITER with counter=WIDTH.
  - Inputs changing after the start cycle have no effect on the operation in flight.
- EXEC (1 cycle) -> DONE; result written on the transition edge.
  - add: result = zero-extended num1 + num2; carry lands in bit WIDTH.
  - sub: result = ({0,num1} - {0,num2}) mod 2^(2*WIDTH), i.e. two's-complement sign-extended.
  - invalid opcode: result=0, error=1.
  - div with num2=0: result={num1, all-ones}, i.e. remainder=num1 and quotient=FFFF; error=1.
- ITER: exactly WIDTH cycles, one bit per cycle, counter decrements; counter==1 -> DONE with result written on that edge.
  - mul: unsigned shift-add, LSB first; result = full 2*WIDTH product.
  - div: restoring divide, MSB first; result[WIDTH-1:0]=quotient, result[2*WIDTH-1:WIDTH]=remainder.
- DONE (1 cycle): done=1 -> IDLE unconditionally. A start in this cycle is ignored.
- Latency (start sampled at edge T): add/sub/invalid/div0 done high in cycle T+2; mul/div done high in cycle T+1+WIDTH (T+17 at default).
- busy=1 from T+1 through the DONE cycle inclusive.
- start while busy: ignored, no queueing.
- clear in EXEC/ITER: next state IDLE, no done, result and error keep their previous values.
- clear in DONE: no effect; done still pulses once.
- clear+start in IDLE: clear wins.
- reset mid-ITER: immediate IDLE, result=0.
- done never asserts for two consecutive cycles.

Optional Feature:
Macro CALC_SEQ_DIV_EN.
- Defined: opcode 011 performs restoring divide as above, including divide-by-zero handling.
- Undefined: divide datapath and remainder register are not synthesized. Opcode 011 is treated as invalid: EXEC, result=0, error=1, done at T+2.

Test Plan:
- add FFFF+0001, start at T -> busy at T+1, done=1 only at T+2, result=0x00010000, error=0.
- sub 0005-0009 -> result=0xFFFFFFFC at done; 0009-0005 -> 0x00000004.
- mul FFFF*FFFF -> done exactly at T+17, result=0xFFFE0001; mul 0000*1234 -> 0x00000000 at T+17.
- div 0064/0007 (DIV_EN defined) -> result=0x0002000E at T+17. Then div 1234/0000 -> result=0x1234FFFF, error=1, done at T+2. Then opcode 111 -> result=0, error=1.
- mul in progress: start pulse at T+5 ignored; clear at T+8 -> IDLE at T+9, no done, result holds the previous value.
- async reset asserted mid-ITER (between clock edges) -> busy=0, result=0 immediately. After release, a fresh add 0002+0003 -> 0x00000005.
